mem_arb2: RTL and testbench



---
 rtl/mem_arb2.sv | 123 ++++++++++++
 tb/tb_mem_arb2.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb2.sv
// Two-master to one-slave request/response fabric in front of the MEM controller.
// Round-robin request arbitration; read responses are routed back in order via an ID FIFO.
module mem_arb2 #(
  parameter int AW    = 21,
  parameter int DW    = 32,
  parameter int SW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_req_vld,
  input  logic [AW-1:0] m0_req_addr,
  input  logic          m0_req_wr,
  input  logic [SW-1:0] m0_req_dat_strb,
  input  logic [DW-1:0] m0_req_dat,
  output logic          m0_req_gnt,
  output logic          m0_rsp_vld,
  output logic [DW-1:0] m0_rsp_dat,
  input  logic          m0_rsp_gnt,
  input  logic          m1_req_vld,
  input  logic [AW-1:0] m1_req_addr,
  input  logic          m1_req_wr,
  input  logic [SW-1:0] m1_req_dat_strb,
  input  logic [DW-1:0] m1_req_dat,
  output logic          m1_req_gnt,
  output logic          m1_rsp_vld,
  output logic [DW-1:0] m1_rsp_dat,
  input  logic          m1_rsp_gnt,
  output logic          s_req_vld,
  output logic [AW-1:0] s_req_addr,
  output logic          s_req_wr,
  output logic [SW-1:0] s_req_dat_strb,
  output logic [DW-1:0] s_req_dat,
  input  logic          s_req_gnt,
  input  logic          s_rsp_vld,
  input  logic [DW-1:0] s_rsp_dat,
  output logic          s_rsp_gnt,
  output logic          err_orphan
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic             pref;
  logic             lock;
  logic             lock_sel;
  logic             sel;
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [DEPTH-1:0] id_mem;
  logic             empty;
  logic             full;
  logic             head;
  logic             elig0;
  logic             elig1;
  logic             req_xfer;
  logic             push;
  logic             pop;

  assign empty = (wp == rp);
  assign full  = (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
  assign head  = id_mem[rp[PW-2:0]];

  // Reads need a free ID slot; a pop in the same cycle does not count.
  assign elig0 = m0_req_vld && (m0_req_wr || !full);
  assign elig1 = m1_req_vld && (m1_req_wr || !full);

  always_comb begin
    sel = 1'b0;
    if (lock)
      sel = lock_sel;
    else if (elig0 && elig1)
      sel = pref;
    else
      sel = elig1;
  end

  assign s_req_vld      = rstn && (sel ? elig1 : elig0);
  assign s_req_addr     = sel ? m1_req_addr     : m0_req_addr;
  assign s_req_wr       = sel ? m1_req_wr       : m0_req_wr;
  assign s_req_dat_strb = sel ? m1_req_dat_strb : m0_req_dat_strb;
  assign s_req_dat      = sel ? m1_req_dat      : m0_req_dat;

  assign m0_req_gnt = s_req_vld && s_req_gnt && !sel;
  assign m1_req_gnt = s_req_vld && s_req_gnt && sel;

  assign req_xfer = s_req_vld && s_req_gnt;
  assign push     = req_xfer && !s_req_wr;

  // With nothing outstanding the response channel drains and drops orphan beats.
  assign m0_rsp_vld = rstn && s_rsp_vld && !empty && !head;
  assign m1_rsp_vld = rstn && s_rsp_vld && !empty && head;
  assign m0_rsp_dat = s_rsp_dat;
  assign m1_rsp_dat = s_rsp_dat;
  assign s_rsp_gnt  = rstn && (empty || (head ? m1_rsp_gnt : m0_rsp_gnt));
  assign pop        = s_rsp_vld && s_rsp_gnt && !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pref       <= 1'b0;
      lock       <= 1'b0;
      lock_sel   <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      id_mem     <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (req_xfer)
        pref <= !sel;
      lock <= s_req_vld && !s_req_gnt;
      if (s_req_vld && !s_req_gnt)
        lock_sel <= sel;
      if (push) begin
        id_mem[wp[PW-2:0]] <= sel;
        wp                 <= wp + PW'(1);
      end
      if (pop)
        rp <= rp + PW'(1);
      if (s_rsp_vld && empty)
        err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: directed vector table, reset-mid-operation sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_mem_arb2;

  logic        clk;
  logic        rstn;
  logic        v[2];
  logic        w[2];
  logic [20:0] ad[2];
  logic [3:0]  st[2];
  logic [31:0] dt[2];
  logic        rg[2];
  logic        sg;
  logic        rv;
  logic [31:0] rdat;

  logic        m0_req_gnt, m1_req_gnt, m0_rsp_vld, m1_rsp_vld;
  logic [31:0] m0_rsp_dat, m1_rsp_dat;
  logic        s_req_vld, s_req_wr, s_rsp_gnt, err_orphan;
  logic [20:0] s_req_addr;
  logic [3:0]  s_req_dat_strb;
  logic [31:0] s_req_dat;

  int tests = 0;
  int fails = 0;

  mem_arb2 dut (
    .clk(clk), .rstn(rstn),
    .m0_req_vld(v[0]), .m0_req_addr(ad[0]), .m0_req_wr(w[0]),
    .m0_req_dat_strb(st[0]), .m0_req_dat(dt[0]), .m0_req_gnt(m0_req_gnt),
    .m0_rsp_vld(m0_rsp_vld), .m0_rsp_dat(m0_rsp_dat), .m0_rsp_gnt(rg[0]),
    .m1_req_vld(v[1]), .m1_req_addr(ad[1]), .m1_req_wr(w[1]),
    .m1_req_dat_strb(st[1]), .m1_req_dat(dt[1]), .m1_req_gnt(m1_req_gnt),
    .m1_rsp_vld(m1_rsp_vld), .m1_rsp_dat(m1_rsp_dat), .m1_rsp_gnt(rg[1]),
    .s_req_vld(s_req_vld), .s_req_addr(s_req_addr), .s_req_wr(s_req_wr),
    .s_req_dat_strb(s_req_dat_strb), .s_req_dat(s_req_dat), .s_req_gnt(sg),
    .s_rsp_vld(rv), .s_rsp_dat(rdat), .s_rsp_gnt(s_rsp_gnt),
    .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // in = {v0,w0,v1,w1,s_req_gnt,s_rsp_vld,rg0,rg1}
  // ex = {s_req_vld,m0_gnt,m1_gnt,s_req_wr,m0_rsp_vld,m1_rsp_vld,s_rsp_gnt,err_orphan}
  typedef struct packed {
    logic [7:0]  in;
    logic [7:0]  ex;
    logic [20:0] addr;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(input logic [7:0] i, input logic [7:0] e, input logic [20:0] a);
    vec_t r;
    r.in = i; r.ex = e; r.addr = a;
    return r;
  endfunction

  // Reference model state
  bit q[$];
  int pref;
  int infl;
  bit merr;
  bit held[2];

  task automatic all_idle();
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; w[i] = 0; ad[i] = '0; st[i] = '0; dt[i] = '0; rg[i] = 0;
    end
    sg = 0; rv = 0; rdat = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " s_req_vld"}, 32'(s_req_vld), 32'd0);
    chk({tag, " m0_req_gnt"}, 32'(m0_req_gnt), 32'd0);
    chk({tag, " m1_req_gnt"}, 32'(m1_req_gnt), 32'd0);
    chk({tag, " m0_rsp_vld"}, 32'(m0_rsp_vld), 32'd0);
    chk({tag, " m1_rsp_vld"}, 32'(m1_rsp_vld), 32'd0);
    chk({tag, " s_rsp_gnt"}, 32'(s_rsp_gnt), 32'd0);
    chk({tag, " err_orphan"}, 32'(err_orphan), 32'd0);
  endtask

  task automatic model_cycle(input int cyc);
    bit e0, e1, sv, xfer, pop, exp_rg, hd;
    int sel;
    bit eg[2];
    bit erv[2];
    e0 = v[0] && (w[0] || q.size() < 4);
    e1 = v[1] && (w[1] || q.size() < 4);
    if (infl >= 0) sel = infl;
    else if (e0 && e1) sel = pref;
    else sel = e1 ? 1 : 0;
    sv = (sel == 1) ? e1 : e0;
    eg[0] = sv && sg && sel == 0;
    eg[1] = sv && sg && sel == 1;
    if (q.size() == 0) begin
      exp_rg = 1; erv[0] = 0; erv[1] = 0;
    end else begin
      hd = q[0];
      exp_rg = rg[hd];
      erv[0] = rv && !hd;
      erv[1] = rv && hd;
    end
    chk($sformatf("rnd%0d s_req_vld", cyc), 32'(s_req_vld), 32'(sv));
    chk($sformatf("rnd%0d m0_req_gnt", cyc), 32'(m0_req_gnt), 32'(eg[0]));
    chk($sformatf("rnd%0d m1_req_gnt", cyc), 32'(m1_req_gnt), 32'(eg[1]));
    if (sv) begin
      chk($sformatf("rnd%0d s_req_addr", cyc), 32'(s_req_addr), 32'(ad[sel]));
      chk($sformatf("rnd%0d s_req_wr", cyc), 32'(s_req_wr), 32'(w[sel]));
      chk($sformatf("rnd%0d s_req_dat", cyc), s_req_dat, dt[sel]);
      chk($sformatf("rnd%0d s_req_strb", cyc), 32'(s_req_dat_strb), 32'(st[sel]));
    end
    chk($sformatf("rnd%0d m0_rsp_vld", cyc), 32'(m0_rsp_vld), 32'(erv[0]));
    chk($sformatf("rnd%0d m1_rsp_vld", cyc), 32'(m1_rsp_vld), 32'(erv[1]));
    chk($sformatf("rnd%0d s_rsp_gnt", cyc), 32'(s_rsp_gnt), 32'(exp_rg));
    chk($sformatf("rnd%0d rsp_dat", cyc), m1_rsp_dat ^ m0_rsp_dat ^ m0_rsp_dat, rdat);
    chk($sformatf("rnd%0d err_orphan", cyc), 32'(err_orphan), 32'(merr));
    // Advance the model as the clock edge will
    pop  = rv && exp_rg && q.size() > 0;
    xfer = sv && sg;
    if (rv && q.size() == 0) merr = 1;
    if (pop) void'(q.pop_front());
    if (xfer) begin
      pref = (sel == 0) ? 1 : 0;
      infl = -1;
      if (!w[sel]) q.push_back(sel[0]);
    end else if (sv) infl = sel;
    else infl = -1;
    for (int i = 0; i < 2; i++) held[i] = v[i] && !eg[i];
  endtask

  initial begin
    tbl[0]  = mk(8'b10101011, 8'b11000010, 21'h100);
    tbl[1]  = mk(8'b10101111, 8'b10101010, 21'h200);
    tbl[2]  = mk(8'b10101111, 8'b11000110, 21'h100);
    tbl[3]  = mk(8'b10101111, 8'b10101010, 21'h200);
    tbl[4]  = mk(8'b00001111, 8'b00000110, 21'h000);
    tbl[5]  = mk(8'b10100011, 8'b10000010, 21'h100);
    tbl[6]  = mk(8'b10100011, 8'b10000010, 21'h100);
    tbl[7]  = mk(8'b10100011, 8'b10000010, 21'h100);
    tbl[8]  = mk(8'b10101011, 8'b11000010, 21'h100);
    tbl[9]  = mk(8'b00101011, 8'b10100010, 21'h200);
    tbl[10] = mk(8'b00000101, 8'b00001000, 21'h000);
    tbl[11] = mk(8'b00000101, 8'b00001000, 21'h000);
    tbl[12] = mk(8'b00000111, 8'b00001010, 21'h000);
    tbl[13] = mk(8'b00000101, 8'b00000110, 21'h000);
    for (int i = 14; i < 18; i++) tbl[i] = mk(8'b00101011, 8'b10100010, 21'h200);
    tbl[18] = mk(8'b11101011, 8'b11010010, 21'h100);
    tbl[19] = mk(8'b00101111, 8'b00000110, 21'h000);
    tbl[20] = mk(8'b00101011, 8'b10100010, 21'h200);
    for (int i = 21; i < 25; i++) tbl[i] = mk(8'b00000111, 8'b00000110, 21'h000);
    tbl[25] = mk(8'b00000100, 8'b00000010, 21'h000);
    tbl[26] = mk(8'b00000000, 8'b00000011, 21'h000);

    // Reset state, with requests and a response beat already present
    all_idle();
    rstn = 0;
    v[0] = 1; v[1] = 1; sg = 1; rv = 1; rg[0] = 1; rg[1] = 1;
    #1;
    chk_quiet("reset");
    @(negedge clk);
    rstn = 1;

    // Directed vector table
    for (int i = 0; i < 27; i++) begin
      {v[0], w[0], v[1], w[1], sg, rv, rg[0], rg[1]} = tbl[i].in;
      ad[0] = 21'h100; ad[1] = 21'h200;
      dt[0] = 32'hDEADBEEF; st[0] = 4'hF;
      dt[1] = 32'h11111111; st[1] = 4'h0;
      rdat = 32'hCAFE0001;
      #1;
      chk($sformatf("row%0d s_req_vld", i), 32'(s_req_vld), 32'(tbl[i].ex[7]));
      chk($sformatf("row%0d m0_req_gnt", i), 32'(m0_req_gnt), 32'(tbl[i].ex[6]));
      chk($sformatf("row%0d m1_req_gnt", i), 32'(m1_req_gnt), 32'(tbl[i].ex[5]));
      if (tbl[i].ex[7]) begin
        chk($sformatf("row%0d s_req_wr", i), 32'(s_req_wr), 32'(tbl[i].ex[4]));
        chk($sformatf("row%0d s_req_addr", i), 32'(s_req_addr), 32'(tbl[i].addr));
        chk($sformatf("row%0d s_req_dat", i), s_req_dat,
            (tbl[i].addr == 21'h100) ? 32'hDEADBEEF : 32'h11111111);
      end
      chk($sformatf("row%0d m0_rsp_vld", i), 32'(m0_rsp_vld), 32'(tbl[i].ex[3]));
      chk($sformatf("row%0d m1_rsp_vld", i), 32'(m1_rsp_vld), 32'(tbl[i].ex[2]));
      chk($sformatf("row%0d s_rsp_gnt", i), 32'(s_rsp_gnt), 32'(tbl[i].ex[1]));
      chk($sformatf("row%0d err_orphan", i), 32'(err_orphan), 32'(tbl[i].ex[0]));
      if (rv) chk($sformatf("row%0d m0_rsp_dat", i), m0_rsp_dat, 32'hCAFE0001);
      @(negedge clk);
    end

    // Reset mid-operation with two reads outstanding
    all_idle();
    ad[0] = 21'h100; ad[1] = 21'h200;
    v[0] = 1; v[1] = 1; sg = 1;
    @(negedge clk);
    @(negedge clk);
    v[0] = 0; v[1] = 0; rv = 0;
    #1;
    chk("pre-reset err_orphan sticky", 32'(err_orphan), 32'd1);
    chk("pre-reset s_rsp_gnt head", 32'(s_rsp_gnt), 32'd0);
    v[0] = 1; v[1] = 1; rv = 1; rg[0] = 1; rg[1] = 1;
    rstn = 0;
    #1;
    chk_quiet("midrst");
    @(negedge clk);
    rstn = 1;
    rg[0] = 0; rg[1] = 0;
    #1;
    chk("postrst m0_req_gnt", 32'(m0_req_gnt), 32'd1);
    chk("postrst m1_req_gnt", 32'(m1_req_gnt), 32'd0);
    chk("postrst s_rsp_gnt empty", 32'(s_rsp_gnt), 32'd1);
    chk("postrst m0_rsp_vld", 32'(m0_rsp_vld), 32'd0);
    chk("postrst m1_rsp_vld", 32'(m1_rsp_vld), 32'd0);
    chk("postrst err_orphan", 32'(err_orphan), 32'd0);
    @(negedge clk);
    all_idle();
    #1;
    chk("orphan sets err", 32'(err_orphan), 32'd1);

    // Randomized traffic against the reference model
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    q.delete();
    pref = 0; infl = -1; merr = 0;
    held[0] = 0; held[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!held[i]) begin
          v[i]  = ($urandom % 3) != 0;
          w[i]  = ($urandom % 4) == 0;
          ad[i] = 21'($urandom);
          st[i] = 4'($urandom);
          dt[i] = $urandom;
        end
        rg[i] = ($urandom % 4) != 0;
      end
      sg   = ($urandom % 4) != 0;
      rv   = (q.size() == 0) ? (($urandom % 40) == 0) : (($urandom % 2) == 0);
      rdat = $urandom;
      #1;
      model_cycle(c);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
